conv_layer_engine: RTL and testbench
====================================

// Module: conv_layer_engine
// PURPOSE
//  Generic, parametrised 2-D convolution layer engine (conv + bias + optional ReLU) for the CNN datapath.
//  Reads activations, weights and biases through 1-cycle-latency memory read ports; computes one output
//  pixel at a time with a single sequential MAC; streams results out with valid/ready backpressure.
//  Replaces fixed-size, fully-parallel conv stages; one instance per layer, sequenced by the top-level controller.
// PARAMETERS
//  IN_CH   16  input channels
//  OUT_CH  32  output filters
//  H       14  input map height;  W 14 input map width
//  K       3   square kernel size
//  PAD     1   zero padding on every side (implicit, never stored)
//  STRIDE  1   convolution stride (1 or 2)
//  DATA_W  32  activation/output width, signed
//  WGT_W   8   weight width, signed
//  ACC_W   48  accumulator width, signed
//  RELU    1   1: clamp negatives to 0; 0: pass signed result
// PORTS
//  clk          in   1                       clock
//  reset        in   1                       asynchronous, active-high
//  start        in   1                       begin layer; sampled only in IDLE
//  busy         out  1                       high from start accept until done
//  done         out  1                       one-cycle pulse after last output accepted
//  act_rd_en    out  1                       activation read strobe
//  act_rd_addr  out  clog2(IN_CH*H*W)        addr = (c*H + r)*W + col
//  act_rd_data  in   DATA_W                  valid 1 cycle after act_rd_en
//  wgt_rd_en    out  1                       weight read strobe
//  wgt_rd_addr  out  clog2(OUT_CH*IN_CH*K*K) addr = ((f*IN_CH + c)*K + m)*K + n
//  wgt_rd_data  in   WGT_W                   valid 1 cycle after wgt_rd_en
//  bias_rd_addr out  clog2(OUT_CH)           = f; bias_rd_data valid 1 cycle after BIAS state
//  bias_rd_data in   DATA_W                  bias of filter f
//  out_valid    out  1                       out_data/out_addr valid
//  out_ready    in   1                       consumer accepts when out_valid && out_ready
//  out_data     out  DATA_W                  result pixel
//  out_addr     out  clog2(OUT_CH*OH*OW)     = (f*OH + i)*OW + j
//  sat_flag     out  1                       sticky: some result clamped; cleared on start accept
// BEHAVIOUR
//  OH = (H + 2*PAD - K)/STRIDE + 1, OW likewise; defaults give 14x14x32. Order: f outer, i, j inner.
//  Reset: state IDLE; busy, done, out_valid, act_rd_en, wgt_rd_en, sat_flag = 0; all addrs/out_data = 0.
//  FSM: IDLE -start-> BIAS (read bias, acc cleared) -> MAC (one tap per cycle, c outer, m, n inner,
//   IN_CH*K*K cycles) -> DRAIN (2 cycles, last products land) -> EMIT (hold out_valid until accepted)
//   -> BIAS for next pixel, or DONE after pixel (OUT_CH-1, OH-1, OW-1) -> IDLE.
//  Tap at (i*STRIDE+m-PAD, j*STRIDE+n-PAD) outside map: no act read issued, product forced to 0;
//   weight read still issued (addresses monotonic). Zero tap flag pipelined alongside read data.
//  MAC: acc += sext(act)*sext(wgt) in ACC_W, full precision; acc seeded with sext(bias).
//  Output: saturate acc to signed DATA_W (set sat_flag on clamp), then ReLU if RELU=1.
//  Per-pixel latency: 1 + IN_CH*K*K + 2 + 1 cycles with out_ready high (148 at defaults).
//  EMIT: out_data/out_addr stable while out_valid && !out_ready; no reads issued during EMIT.
//  done pulses the cycle after final handshake; busy drops same cycle. start while busy ignored.
//  Reset mid-layer: immediate return to reset values; partial results discarded, no done.
// STRUCTURE
//  conv_pkg: state enum (IDLE,BIAS,MAC,DRAIN,EMIT,DONE), sat_signed() function, out-dim helpers.
//  Sub-module conv_mac_unit: 2-stage registered multiply + accumulate, zero-tap gating, clear/seed input.
//  Top holds FSM, nested counters (f,i,j,c,m,n), address generation, output register.
// TESTING
//  All act=1, all wgt=1, bias=0 -> centre pixel 144, edge 96, corner 64; 6272 outputs, ordered addrs.
//  Same data, bias=-1000: RELU=1 -> centre 0; RELU=0 -> centre -856, corner -936.
//  out_ready low 10 cycles at pixel 5 -> out_valid held, data/addr stable, no rd_en pulses, then resume.
//  act=2^31-1, wgt=127 -> out_data 0x7FFFFFFF, sat_flag=1; next start clears sat_flag.
//  Reset after 50 outputs -> all outputs 0 next cycle, no done; restart yields full correct map.
//  STRIDE=2, H=W=14 -> 7x7 per filter, 1568 outputs, pixel (i,j) centred at input (2i,2j).

Source files
------------

// File: rtl/conv_pkg.sv
// Shared state encoding and elaboration-time helpers for the convolution layer engine.
// Saturation is done in a fixed 64-bit domain so one function serves any ACC_W/DATA_W pair.
package conv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        BIAS,
        MAC,
        DRAIN,
        EMIT,
        DONE
    } conv_state_t;

    localparam int SAT_W = 64;

    function automatic int out_dim(input int n, input int k, input int pad, input int stride);
        return (n + 2 * pad - k) / stride + 1;
    endfunction

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic signed [SAT_W-1:0] sat_signed(input logic signed [SAT_W-1:0] v,
                                                           input int w);
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        logic signed [SAT_W-1:0] res;
        hi  = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo  = -(64'sd1 <<< (w - 1));
        res = v;
        if (v > hi) res = hi;
        if (v < lo) res = lo;
        return res;
    endfunction

endpackage

// File: rtl/conv_mac_unit.sv
// Two-stage multiply-accumulate: stage 1 registers the gated product of the returning read data,
// stage 2 folds it into the accumulator. acc_next is exposed so the owner can capture the final sum.
module conv_mac_unit
    import conv_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int WGT_W  = 8,
    parameter int ACC_W  = 48
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     seed,
    input  logic signed [DATA_W-1:0] seed_val,
    input  logic                     tap_issue,
    input  logic                     tap_zero,
    input  logic signed [DATA_W-1:0] act,
    input  logic signed [WGT_W-1:0]  wgt,
    output logic signed [ACC_W-1:0]  acc_next
);

    logic                    tap_valid_q;
    logic                    tap_zero_q;
    logic signed [ACC_W-1:0] prod_q;
    logic signed [ACC_W-1:0] acc;

    // The tap flags travel one cycle to line up with the memory read data they describe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tap_valid_q <= 1'b0;
            tap_zero_q  <= 1'b0;
            prod_q      <= '0;
            acc         <= '0;
        end else begin
            tap_valid_q <= tap_issue;
            tap_zero_q  <= tap_zero;
            prod_q      <= (tap_valid_q && !tap_zero_q) ? ACC_W'(act) * ACC_W'(wgt) : '0;
            acc         <= acc_next;
        end
    end

    always_comb begin
        acc_next = acc + prod_q;
        if (seed)  acc_next = ACC_W'(seed_val);
        if (clear) acc_next = '0;
    end

endmodule

// File: rtl/conv_layer_engine.sv
// Sequential conv + bias + optional ReLU layer: one output pixel at a time through a single MAC,
// padding handled implicitly by suppressing out-of-map activation reads.
module conv_layer_engine
    import conv_pkg::*;
#(
    parameter int IN_CH  = 16,
    parameter int OUT_CH = 32,
    parameter int H      = 14,
    parameter int W      = 14,
    parameter int K      = 3,
    parameter int PAD    = 1,
    parameter int STRIDE = 1,
    parameter int DATA_W = 32,
    parameter int WGT_W  = 8,
    parameter int ACC_W  = 48,
    parameter int RELU   = 1,
    localparam int OH      = out_dim(H, K, PAD, STRIDE),
    localparam int OW      = out_dim(W, K, PAD, STRIDE),
    localparam int ACT_AW  = cnt_w(IN_CH * H * W),
    localparam int WGT_AW  = cnt_w(OUT_CH * IN_CH * K * K),
    localparam int BIAS_AW = cnt_w(OUT_CH),
    localparam int OUT_AW  = cnt_w(OUT_CH * OH * OW)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic                     act_rd_en,
    output logic [ACT_AW-1:0]        act_rd_addr,
    input  logic signed [DATA_W-1:0] act_rd_data,
    output logic                     wgt_rd_en,
    output logic [WGT_AW-1:0]        wgt_rd_addr,
    input  logic signed [WGT_W-1:0]  wgt_rd_data,
    output logic [BIAS_AW-1:0]       bias_rd_addr,
    input  logic signed [DATA_W-1:0] bias_rd_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_data,
    output logic [OUT_AW-1:0]        out_addr,
    output logic                     sat_flag
);

    localparam int FW = cnt_w(OUT_CH);
    localparam int IW = cnt_w(OH);
    localparam int JW = cnt_w(OW);
    localparam int CW = cnt_w(IN_CH);
    localparam int KW = cnt_w(K);

    conv_state_t state, state_next;

    logic [FW-1:0] f;
    logic [IW-1:0] i;
    logic [JW-1:0] j;
    logic [CW-1:0] c;
    logic [KW-1:0] m, n;
    logic          drain_cnt;

    int  row, col;
    logic outside, first_tap, last_tap, last_pixel, clamp;
    logic signed [ACC_W-1:0]  mac_next;
    logic signed [SAT_W-1:0]  acc_ext, acc_sat;
    logic signed [DATA_W-1:0] pix;

    always_comb begin
        row        = int'(i) * STRIDE + int'(m) - PAD;
        col        = int'(j) * STRIDE + int'(n) - PAD;
        outside    = (row < 0) || (row >= H) || (col < 0) || (col >= W);
        first_tap  = (c == '0) && (m == '0) && (n == '0);
        last_tap   = (c == CW'(IN_CH - 1)) && (m == KW'(K - 1)) && (n == KW'(K - 1));
        last_pixel = (f == FW'(OUT_CH - 1)) && (i == IW'(OH - 1)) && (j == JW'(OW - 1));
    end

    // Addresses are parked at zero whenever their strobe is low.
    always_comb begin
        act_rd_addr  = act_rd_en ? ACT_AW'((int'(c) * H + row) * W + col) : '0;
        wgt_rd_addr  = wgt_rd_en ?
                       WGT_AW'(((int'(f) * IN_CH + int'(c)) * K + int'(m)) * K + int'(n)) : '0;
        bias_rd_addr = BIAS_AW'(f);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        out_valid  = 1'b0;
        act_rd_en  = 1'b0;
        wgt_rd_en  = 1'b0;
        case (state)
            IDLE:  if (start) state_next = BIAS;
            BIAS: begin
                busy       = 1'b1;
                state_next = MAC;
            end
            MAC: begin
                busy      = 1'b1;
                wgt_rd_en = 1'b1;
                act_rd_en = !outside;
                if (last_tap) state_next = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (drain_cnt) state_next = EMIT;
            end
            EMIT: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) state_next = last_pixel ? DONE : BIAS;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    conv_mac_unit #(
        .DATA_W(DATA_W),
        .WGT_W (WGT_W),
        .ACC_W (ACC_W)
    ) u_mac (
        .clk      (clk),
        .reset    (reset),
        .clear    (state == BIAS),
        .seed     ((state == MAC) && first_tap),
        .seed_val (bias_rd_data),
        .tap_issue(state == MAC),
        .tap_zero (outside),
        .act      (act_rd_data),
        .wgt      (wgt_rd_data),
        .acc_next (mac_next)
    );

    always_comb begin
        acc_ext = SAT_W'(mac_next);
        acc_sat = sat_signed(acc_ext, DATA_W);
        clamp   = (acc_sat != acc_ext);
        pix     = ((RELU != 0) && (acc_sat < 0)) ? '0 : acc_sat[DATA_W-1:0];
    end

    // The output register captures the complete sum on the second drain cycle, so EMIT holds it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            f         <= '0;
            i         <= '0;
            j         <= '0;
            c         <= '0;
            m         <= '0;
            n         <= '0;
            drain_cnt <= 1'b0;
            out_data  <= '0;
            out_addr  <= '0;
            sat_flag  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    f        <= '0;
                    i        <= '0;
                    j        <= '0;
                    c        <= '0;
                    m        <= '0;
                    n        <= '0;
                    sat_flag <= 1'b0;
                end
                MAC: begin
                    if (n == KW'(K - 1)) begin
                        n <= '0;
                        if (m == KW'(K - 1)) begin
                            m <= '0;
                            c <= (c == CW'(IN_CH - 1)) ? '0 : c + 1'b1;
                        end else begin
                            m <= m + 1'b1;
                        end
                    end else begin
                        n <= n + 1'b1;
                    end
                end
                DRAIN: begin
                    drain_cnt <= !drain_cnt;
                    if (drain_cnt) begin
                        out_data <= pix;
                        out_addr <= OUT_AW'((int'(f) * OH + int'(i)) * OW + int'(j));
                        if (clamp) sat_flag <= 1'b1;
                    end
                end
                EMIT: if (out_ready) begin
                    if (j == JW'(OW - 1)) begin
                        j <= '0;
                        if (i == IW'(OH - 1)) begin
                            i <= '0;
                            f <= (f == FW'(OUT_CH - 1)) ? '0 : f + 1'b1;
                        end else begin
                            i <= i + 1'b1;
                        end
                    end else begin
                        j <= j + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_layer_engine.sv
// Randomised bench for conv_layer_engine: memory models, a loop-based convolution reference,
// and a negedge monitor that scores every emitted pixel against the reference queue.
module tb_conv_layer_engine;

    localparam int IN_CH  = 3;
    localparam int OUT_CH = 2;
    localparam int H      = 5;
    localparam int W      = 7;
    localparam int K      = 3;
    localparam int PAD    = 1;
    localparam int STRIDE = 2;
    localparam int DATA_W = 32;
    localparam int WGT_W  = 8;
    localparam int ACC_W  = 48;
    localparam int RELU   = 1;

    localparam int OH      = (H + 2 * PAD - K) / STRIDE + 1;
    localparam int OW      = (W + 2 * PAD - K) / STRIDE + 1;
    localparam int ACT_N   = IN_CH * H * W;
    localparam int WGT_N   = OUT_CH * IN_CH * K * K;
    localparam int ACT_AW  = $clog2(ACT_N);
    localparam int WGT_AW  = $clog2(WGT_N);
    localparam int BIAS_AW = (OUT_CH > 1) ? $clog2(OUT_CH) : 1;
    localparam int OUT_AW  = $clog2(OUT_CH * OH * OW);
    localparam int LAT     = 1 + IN_CH * K * K + 2 + 1;
    localparam longint MAXV = (64'sd1 <<< (DATA_W - 1)) - 1;
    localparam longint MINV = -(64'sd1 <<< (DATA_W - 1));

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                     reset, start, out_ready;
    logic                     busy, done, act_rd_en, wgt_rd_en, out_valid, sat_flag;
    logic [ACT_AW-1:0]        act_rd_addr;
    logic [WGT_AW-1:0]        wgt_rd_addr;
    logic [BIAS_AW-1:0]       bias_rd_addr;
    logic [OUT_AW-1:0]        out_addr;
    logic signed [DATA_W-1:0] act_rd_data, bias_rd_data, out_data;
    logic signed [WGT_W-1:0]  wgt_rd_data;

    logic signed [DATA_W-1:0] act_mem  [ACT_N];
    logic signed [WGT_W-1:0]  wgt_mem  [WGT_N];
    logic signed [DATA_W-1:0] bias_mem [OUT_CH];

    longint exp_addr[$];
    longint exp_data[$];
    bit     exp_sat;
    bit     gap_check;
    int     checks = 0, errors = 0;
    int     cycle = 0, accepted = 0, last_hs = -1, emit_reads = 0, bad_addr = 0;
    bit     prev_stall = 1'b0;

    conv_layer_engine #(
        .IN_CH(IN_CH), .OUT_CH(OUT_CH), .H(H), .W(W), .K(K), .PAD(PAD), .STRIDE(STRIDE),
        .DATA_W(DATA_W), .WGT_W(WGT_W), .ACC_W(ACC_W), .RELU(RELU)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .act_rd_en   (act_rd_en),
        .act_rd_addr (act_rd_addr),
        .act_rd_data (act_rd_data),
        .wgt_rd_en   (wgt_rd_en),
        .wgt_rd_addr (wgt_rd_addr),
        .wgt_rd_data (wgt_rd_data),
        .bias_rd_addr(bias_rd_addr),
        .bias_rd_data(bias_rd_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_addr    (out_addr),
        .sat_flag    (sat_flag)
    );

    task automatic checkOutput(input string tag, input longint observed, input longint expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Unrequested reads return junk so a missing zero-tap gate shows up in the sums.
    always @(posedge clk) begin
        cycle <= cycle + 1;
        if (act_rd_en && int'(act_rd_addr) < ACT_N) act_rd_data <= act_mem[act_rd_addr];
        else                                       act_rd_data <= DATA_W'($urandom);
        if (wgt_rd_en && int'(wgt_rd_addr) < WGT_N) wgt_rd_data <= wgt_mem[wgt_rd_addr];
        else                                        wgt_rd_data <= WGT_W'($urandom);
        if (int'(bias_rd_addr) < OUT_CH) bias_rd_data <= bias_mem[bias_rd_addr];
        if ((act_rd_en && int'(act_rd_addr) >= ACT_N) || (wgt_rd_en && int'(wgt_rd_addr) >= WGT_N))
            bad_addr <= bad_addr + 1;
    end

    always @(negedge clk) begin
        if (reset) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall) checkOutput("hold_valid", out_valid, 1);
            if (out_valid && (act_rd_en || wgt_rd_en)) emit_reads <= emit_reads + 1;
            if (out_valid) begin
                if (exp_addr.size() == 0) begin
                    checkOutput("extra_output", 1, 0);
                end else begin
                    checkOutput("out_addr", out_addr, exp_addr[0]);
                    checkOutput("out_data", $signed(out_data), exp_data[0]);
                    if (out_ready) begin
                        void'(exp_addr.pop_front());
                        void'(exp_data.pop_front());
                    end
                end
            end
            if (out_valid && out_ready) begin
                accepted <= accepted + 1;
                if (gap_check && last_hs >= 0) checkOutput("pixel_latency", cycle - last_hs, LAT);
                last_hs <= cycle;
            end else if (!busy && !done) begin
                last_hs <= -1;
            end
            prev_stall <= out_valid && !out_ready;
        end
    end

    task automatic fillMemories(input int kind);
        for (int a = 0; a < ACT_N; a++)
            case (kind)
                0:       act_mem[a] = DATA_W'($urandom_range(4000) - 2000);
                1:       act_mem[a] = 1;
                2:       act_mem[a] = DATA_W'(MAXV);
                default: act_mem[a] = DATA_W'($urandom);
            endcase
        for (int a = 0; a < WGT_N; a++)
            wgt_mem[a] = (kind == 1) ? 8'sd1 : (kind == 2) ? 8'sd127 : WGT_W'($urandom);
        for (int a = 0; a < OUT_CH; a++)
            bias_mem[a] = (kind == 0 || kind == 3) ? DATA_W'($urandom_range(10000) - 5000) : 0;
    endtask

    task automatic buildExpected();
        exp_addr.delete();
        exp_data.delete();
        exp_sat = 1'b0;
        for (int f = 0; f < OUT_CH; f++)
            for (int i = 0; i < OH; i++)
                for (int j = 0; j < OW; j++) begin
                    longint s;
                    s = longint'(bias_mem[f]);
                    for (int c = 0; c < IN_CH; c++)
                        for (int m = 0; m < K; m++)
                            for (int n = 0; n < K; n++) begin
                                int r, q;
                                r = i * STRIDE + m - PAD;
                                q = j * STRIDE + n - PAD;
                                if (r >= 0 && r < H && q >= 0 && q < W)
                                    s += longint'(act_mem[(c * H + r) * W + q]) *
                                         longint'(wgt_mem[((f * IN_CH + c) * K + m) * K + n]);
                            end
                    if (s > MAXV) begin s = MAXV; exp_sat = 1'b1; end
                    else if (s < MINV) begin s = MINV; exp_sat = 1'b1; end
                    if (RELU != 0 && s < 0) s = 0;
                    exp_addr.push_back((f * OH + i) * OW + j);
                    exp_data.push_back(s);
                end
    endtask

    // mode 0: ready always high, 1: random ready plus a start pulse while busy,
    // 2: ready withheld for 10 cycles on pixel 5. abort_at >= 0 resets after that many outputs.
    task automatic applyStimulus(input int mode, input int abort_at);
        int  base, stall, idle_bad;
        bit  seen_done, aborted;
        buildExpected();
        gap_check = (mode == 0);
        stall     = 0;
        seen_done = 1'b0;
        aborted   = 1'b0;
        @(posedge clk); #1;
        base      = accepted;
        start     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checkOutput("busy_after_start", busy, 1);
        checkOutput("sat_clear_on_start", sat_flag, 0);
        for (int cyc = 0; cyc < 20000 && !seen_done && !aborted; cyc++) begin
            if (abort_at >= 0 && accepted - base == abort_at) begin
                reset = 1'b1;
                #1;
                checkOutput("abort_busy", busy, 0);
                checkOutput("abort_valid", out_valid, 0);
                checkOutput("abort_done", done, 0);
                checkOutput("abort_data", out_data, 0);
                checkOutput("abort_addr", out_addr, 0);
                checkOutput("abort_rd_en", act_rd_en | wgt_rd_en, 0);
                repeat (2) @(posedge clk);
                #1;
                reset    = 1'b0;
                idle_bad = 0;
                repeat (20) begin
                    @(posedge clk); #1;
                    if (done || busy) idle_bad++;
                end
                checkOutput("idle_after_abort", idle_bad, 0);
                aborted = 1'b1;
            end else begin
                case (mode)
                    0: out_ready = 1'b1;
                    1: out_ready = ($urandom_range(3) != 0);
                    default: begin
                        if (accepted - base == 5 && out_valid && stall < 10) begin
                            out_ready = 1'b0;
                            stall++;
                        end else begin
                            out_ready = 1'b1;
                        end
                    end
                endcase
                start = (mode == 1 && cyc == 40);
                @(posedge clk); #1;
                start = 1'b0;
                if (done) seen_done = 1'b1;
            end
        end
        if (!aborted) begin
            if (!seen_done) begin
                checkOutput("done_timeout", 0, 1);
            end else begin
                checkOutput("done_timing", cycle - last_hs, 1);
                checkOutput("busy_at_done", busy, 0);
                checkOutput("outputs_remaining", exp_addr.size(), 0);
                checkOutput("outputs_accepted", accepted - base, OUT_CH * OH * OW);
                checkOutput("sat_flag", sat_flag, exp_sat);
                @(posedge clk); #1;
                checkOutput("done_pulse_width", done, 0);
            end
            if (mode == 2) checkOutput("stall_cycles", stall, 10);
        end
        gap_check = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        out_ready = 1'b0;
        gap_check = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_valid", out_valid, 0);
        checkOutput("reset_act_en", act_rd_en, 0);
        checkOutput("reset_wgt_en", wgt_rd_en, 0);
        checkOutput("reset_sat", sat_flag, 0);
        checkOutput("reset_data", out_data, 0);
        checkOutput("reset_addr", out_addr, 0);
        checkOutput("reset_act_addr", act_rd_addr, 0);
        checkOutput("reset_wgt_addr", wgt_rd_addr, 0);
        checkOutput("reset_bias_addr", bias_rd_addr, 0);
        reset = 1'b0;

        $display("[TB] random data, random backpressure");
        fillMemories(0);
        applyStimulus(1, -1);
        $display("[TB] all-ones data, ready high");
        fillMemories(1);
        applyStimulus(0, -1);
        $display("[TB] saturating data, stall on pixel 5");
        fillMemories(2);
        applyStimulus(2, -1);
        $display("[TB] full-range random data");
        fillMemories(3);
        applyStimulus(1, -1);
        $display("[TB] reset mid-layer, then rerun");
        fillMemories(0);
        applyStimulus(0, 10);
        applyStimulus(0, -1);

        checkOutput("reads_during_emit", emit_reads, 0);
        checkOutput("addr_out_of_range", bad_addr, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
